register_file_mp: RTL and testbench

Parametrised multi-port register file for the pipelined core: 3 combinational read ports, 2 synchronous write ports, optional same-cycle write-to-read bypass, and a per-register busy scoreboard.
- The PC index is not stored. It reads the externally supplied PC value.
- Sits between decode (reads, busy check, issue marking) and writeback (both write ports).
- Write port A carries ALU/load results; port B carries base-register writeback / link.

---
 rtl/register_file_mp.sv | 109 ++++++++++
 tb/tb_register_file_mp.sv | 175 +++++++++++++++++
 2 files changed

// File: rtl/register_file_mp.sv
// Multi-port register file: 3 combinational reads, 2 writes (port A wins on collision),
// optional same-cycle write bypass, and a per-register busy scoreboard. PC_INDEX reads pc_in.
module register_file_mp #(
  parameter int WIDTH    = 32,
  parameter int ADDR_W   = 4,
  parameter int PC_INDEX = 15,
  parameter int BYPASS   = 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              we_a,
  input  logic [ADDR_W-1:0] waddr_a,
  input  logic [WIDTH-1:0]  wdata_a,
  input  logic              we_b,
  input  logic [ADDR_W-1:0] waddr_b,
  input  logic [WIDTH-1:0]  wdata_b,
  input  logic [ADDR_W-1:0] raddr_0,
  input  logic [ADDR_W-1:0] raddr_1,
  input  logic [ADDR_W-1:0] raddr_2,
  output logic [WIDTH-1:0]  rdata_0,
  output logic [WIDTH-1:0]  rdata_1,
  output logic [WIDTH-1:0]  rdata_2,
  output logic              busy_0,
  output logic              busy_1,
  output logic              busy_2,
  input  logic [WIDTH-1:0]  pc_in,
  input  logic              mark_en,
  input  logic [ADDR_W-1:0] mark_addr
);

  localparam int NUM_REGS = 2 ** ADDR_W;
  localparam logic [ADDR_W-1:0] PC_A = ADDR_W'(PC_INDEX);

  logic [WIDTH-1:0]    regs_q [NUM_REGS];
  logic [WIDTH-1:0]    regs_d [NUM_REGS];
  logic [NUM_REGS-1:0] busy_q, busy_d;

  logic wr_a_ok, wr_b_ok, mark_ok;
  assign wr_a_ok = we_a && (waddr_a != PC_A);
  assign wr_b_ok = we_b && (waddr_b != PC_A);
  assign mark_ok = mark_en && (mark_addr != PC_A);

  // Port A is applied after port B so it wins a same-address collision;
  // the mark is applied last so a new producer supersedes a completing write.
  always_comb begin
    regs_d = regs_q;
    busy_d = busy_q;
    if (wr_b_ok) begin
      regs_d[waddr_b] = wdata_b;
      busy_d[waddr_b] = 1'b0;
    end
    if (wr_a_ok) begin
      regs_d[waddr_a] = wdata_a;
      busy_d[waddr_a] = 1'b0;
    end
    if (mark_ok) begin
      busy_d[mark_addr] = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < NUM_REGS; i++) begin
        regs_q[i] <= '0;
      end
      busy_q <= '0;
    end else begin
      regs_q <= regs_d;
      busy_q <= busy_d;
    end
  end

  logic [ADDR_W-1:0] raddr_v [3];
  logic [WIDTH-1:0]  rdata_v [3];
  logic              busy_v  [3];

  assign raddr_v[0] = raddr_0;
  assign raddr_v[1] = raddr_1;
  assign raddr_v[2] = raddr_2;

  for (genvar k = 0; k < 3; k++) begin : g_rd
    logic [WIDTH-1:0] rd;
    logic             bz;
    always_comb begin
      rd = regs_q[raddr_v[k]];
      bz = busy_q[raddr_v[k]];
      if (raddr_v[k] == PC_A) begin
        rd = pc_in;
        bz = 1'b0;
      end else if ((BYPASS != 0) && we_a && (waddr_a == raddr_v[k])) begin
        rd = wdata_a;
        bz = 1'b0;
      end else if ((BYPASS != 0) && we_b && (waddr_b == raddr_v[k])) begin
        rd = wdata_b;
        bz = 1'b0;
      end
    end
    assign rdata_v[k] = rd;
    assign busy_v[k]  = bz;
  end

  assign rdata_0 = rdata_v[0];
  assign rdata_1 = rdata_v[1];
  assign rdata_2 = rdata_v[2];
  assign busy_0  = busy_v[0];
  assign busy_1  = busy_v[1];
  assign busy_2  = busy_v[2];

endmodule

// File: tb/tb_register_file_mp.sv
// Directed bench: one bypassing and one non-bypassing instance share all inputs;
// a vector table covers writes, collisions, PC index and scoreboard, plus reset sequences.
module tb_register_file_mp;

  logic        clk = 1'b0;
  logic        reset;
  logic        we_a, we_b, mark_en;
  logic [3:0]  waddr_a, waddr_b, mark_addr;
  logic [31:0] wdata_a, wdata_b, pc_in;
  logic [3:0]  raddr_0, raddr_1, raddr_2;
  logic [31:0] rb0, rb1, rb2, rn0, rn1, rn2;
  logic        bb0, bb1, bb2, bn0, bn1, bn2;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  register_file_mp #(.WIDTH(32), .ADDR_W(4), .PC_INDEX(15), .BYPASS(1)) u_byp (
    .clk(clk), .reset(reset),
    .we_a(we_a), .waddr_a(waddr_a), .wdata_a(wdata_a),
    .we_b(we_b), .waddr_b(waddr_b), .wdata_b(wdata_b),
    .raddr_0(raddr_0), .raddr_1(raddr_1), .raddr_2(raddr_2),
    .rdata_0(rb0), .rdata_1(rb1), .rdata_2(rb2),
    .busy_0(bb0), .busy_1(bb1), .busy_2(bb2),
    .pc_in(pc_in), .mark_en(mark_en), .mark_addr(mark_addr)
  );

  register_file_mp #(.WIDTH(32), .ADDR_W(4), .PC_INDEX(15), .BYPASS(0)) u_nob (
    .clk(clk), .reset(reset),
    .we_a(we_a), .waddr_a(waddr_a), .wdata_a(wdata_a),
    .we_b(we_b), .waddr_b(waddr_b), .wdata_b(wdata_b),
    .raddr_0(raddr_0), .raddr_1(raddr_1), .raddr_2(raddr_2),
    .rdata_0(rn0), .rdata_1(rn1), .rdata_2(rn2),
    .busy_0(bn0), .busy_1(bn1), .busy_2(bn2),
    .pc_in(pc_in), .mark_en(mark_en), .mark_addr(mark_addr)
  );

  typedef struct {
    logic        we_a; logic [3:0] wa; logic [31:0] wda;
    logic        we_b; logic [3:0] wb; logic [31:0] wdb;
    logic        mk;   logic [3:0] ma;
    logic [3:0]  ra0, ra1, ra2;
    logic [31:0] pc;
    logic [31:0] xb0, xb1, xb2; logic [2:0] xbs;
    logic [31:0] xn0, xn1, xn2; logic [2:0] xns;
  } vec_t;

  localparam int NV = 17;
  vec_t vecs [NV];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic idle_inputs();
    we_a = 1'b0; waddr_a = '0; wdata_a = '0;
    we_b = 1'b0; waddr_b = '0; wdata_b = '0;
    mark_en = 1'b0; mark_addr = '0;
  endtask

  task automatic check_both(input string tag,
                            input logic [31:0] b0, input logic [31:0] b1, input logic [31:0] b2,
                            input logic [2:0] bs,
                            input logic [31:0] n0, input logic [31:0] n1, input logic [31:0] n2,
                            input logic [2:0] ns);
    check({tag, ".byp.rd0"}, rb0, b0);
    check({tag, ".byp.rd1"}, rb1, b1);
    check({tag, ".byp.rd2"}, rb2, b2);
    check({tag, ".byp.busy"}, {29'd0, bb2, bb1, bb0}, {29'd0, bs});
    check({tag, ".nob.rd0"}, rn0, n0);
    check({tag, ".nob.rd1"}, rn1, n1);
    check({tag, ".nob.rd2"}, rn2, n2);
    check({tag, ".nob.busy"}, {29'd0, bn2, bn1, bn0}, {29'd0, ns});
  endtask

  initial begin
    // we_a wa wda | we_b wb wdb | mk ma | ra0 ra1 ra2 | pc | byp rd0..2 busy | nob rd0..2 busy
    vecs[0]  = '{1, 3, 32'hDEADBEEF, 1, 7, 32'h12345678, 0, 0, 3, 7, 5, 32'h100,
                 32'hDEADBEEF, 32'h12345678, 0, 3'b000, 0, 0, 0, 3'b000};
    vecs[1]  = '{0, 0, 0, 0, 0, 0, 0, 0, 3, 7, 0, 32'h100,
                 32'hDEADBEEF, 32'h12345678, 0, 3'b000, 32'hDEADBEEF, 32'h12345678, 0, 3'b000};
    vecs[2]  = '{1, 5, 32'hA5A5A5A5, 0, 0, 0, 0, 0, 5, 3, 15, 32'h100,
                 32'hA5A5A5A5, 32'hDEADBEEF, 32'h100, 3'b000, 0, 32'hDEADBEEF, 32'h100, 3'b000};
    vecs[3]  = '{0, 0, 0, 0, 0, 0, 0, 0, 5, 5, 15, 32'h200,
                 32'hA5A5A5A5, 32'hA5A5A5A5, 32'h200, 3'b000, 32'hA5A5A5A5, 32'hA5A5A5A5, 32'h200, 3'b000};
    vecs[4]  = '{1, 2, 32'h1111, 1, 2, 32'h2222, 0, 0, 2, 2, 7, 32'h100,
                 32'h1111, 32'h1111, 32'h12345678, 3'b000, 0, 0, 32'h12345678, 3'b000};
    vecs[5]  = '{1, 15, 32'hFFFF, 0, 0, 0, 0, 0, 2, 15, 14, 32'h100,
                 32'h1111, 32'h100, 0, 3'b000, 32'h1111, 32'h100, 0, 3'b000};
    vecs[6]  = '{0, 0, 0, 1, 15, 32'hEEEE, 0, 0, 15, 13, 5, 32'h300,
                 32'h300, 0, 32'hA5A5A5A5, 3'b000, 32'h300, 0, 32'hA5A5A5A5, 3'b000};
    vecs[7]  = '{0, 0, 0, 0, 0, 0, 1, 9, 9, 9, 15, 32'h100,
                 0, 0, 32'h100, 3'b000, 0, 0, 32'h100, 3'b000};
    vecs[8]  = '{1, 9, 32'h9999, 0, 0, 0, 1, 9, 9, 15, 3, 32'h100,
                 32'h9999, 32'h100, 32'hDEADBEEF, 3'b000, 0, 32'h100, 32'hDEADBEEF, 3'b001};
    vecs[9]  = '{0, 0, 0, 0, 0, 0, 0, 0, 9, 3, 2, 32'h100,
                 32'h9999, 32'hDEADBEEF, 32'h1111, 3'b001, 32'h9999, 32'hDEADBEEF, 32'h1111, 3'b001};
    vecs[10] = '{0, 0, 0, 1, 9, 32'h7777, 0, 0, 9, 2, 4, 32'h100,
                 32'h7777, 32'h1111, 0, 3'b000, 32'h9999, 32'h1111, 0, 3'b001};
    vecs[11] = '{0, 0, 0, 0, 0, 0, 0, 0, 9, 2, 4, 32'h100,
                 32'h7777, 32'h1111, 0, 3'b000, 32'h7777, 32'h1111, 0, 3'b000};
    vecs[12] = '{0, 0, 0, 0, 0, 0, 1, 15, 15, 9, 0, 32'h100,
                 32'h100, 32'h7777, 0, 3'b000, 32'h100, 32'h7777, 0, 3'b000};
    vecs[13] = '{0, 0, 0, 0, 0, 0, 0, 0, 15, 9, 5, 32'h100,
                 32'h100, 32'h7777, 32'hA5A5A5A5, 3'b000, 32'h100, 32'h7777, 32'hA5A5A5A5, 3'b000};
    vecs[14] = '{0, 0, 0, 0, 0, 0, 1, 6, 6, 15, 9, 32'h100,
                 0, 32'h100, 32'h7777, 3'b000, 0, 32'h100, 32'h7777, 3'b000};
    vecs[15] = '{0, 0, 0, 0, 0, 0, 1, 6, 6, 6, 1, 32'h100,
                 0, 0, 0, 3'b011, 0, 0, 0, 3'b011};
    vecs[16] = '{0, 0, 0, 0, 0, 0, 0, 0, 6, 1, 15, 32'h100,
                 0, 0, 32'h100, 3'b001, 0, 0, 32'h100, 3'b001};

    reset = 1'b1;
    idle_inputs();
    pc_in = 32'h100;
    raddr_0 = '0; raddr_1 = '0; raddr_2 = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;

    // Post-reset sweep of every address.
    for (int a = 0; a < 16; a++) begin
      raddr_0 = 4'(a); raddr_1 = 4'(15 - a); raddr_2 = 4'(a);
      #1;
      check($sformatf("reset.byp.r%0d", a), rb0, (a == 15) ? 32'h100 : 32'h0);
      check($sformatf("reset.nob.r%0d", a), rn1, (a == 0) ? 32'h100 : 32'h0);
      check($sformatf("reset.busy.r%0d", a), {28'd0, bb0, bb1, bn0, bn1}, 32'h0);
    end

    for (int i = 0; i < NV; i++) begin
      @(negedge clk);
      we_a = vecs[i].we_a; waddr_a = vecs[i].wa; wdata_a = vecs[i].wda;
      we_b = vecs[i].we_b; waddr_b = vecs[i].wb; wdata_b = vecs[i].wdb;
      mark_en = vecs[i].mk; mark_addr = vecs[i].ma;
      raddr_0 = vecs[i].ra0; raddr_1 = vecs[i].ra1; raddr_2 = vecs[i].ra2;
      pc_in = vecs[i].pc;
      #4;
      check_both($sformatf("v%0d", i),
                 vecs[i].xb0, vecs[i].xb1, vecs[i].xb2, vecs[i].xbs,
                 vecs[i].xn0, vecs[i].xn1, vecs[i].xn2, vecs[i].xns);
    end

    // Write+mark r4, then a reset edge that also carries a write must win.
    @(negedge clk);
    idle_inputs();
    pc_in = 32'h100;
    we_a = 1'b1; waddr_a = 4'd4; wdata_a = 32'h55;
    mark_en = 1'b1; mark_addr = 4'd4;
    raddr_0 = 4'd4; raddr_1 = 4'd6; raddr_2 = 4'd3;
    #4;
    check_both("rst.wr", 32'h55, 0, 32'hDEADBEEF, 3'b010, 0, 0, 32'hDEADBEEF, 3'b010);
    @(negedge clk);
    idle_inputs();
    #4;
    check_both("rst.pre", 32'h55, 0, 32'hDEADBEEF, 3'b011, 32'h55, 0, 32'hDEADBEEF, 3'b011);
    @(negedge clk);
    reset = 1'b1;
    we_a = 1'b1; waddr_a = 4'd4; wdata_a = 32'h99;
    mark_en = 1'b1; mark_addr = 4'd4;
    @(negedge clk);
    reset = 1'b0;
    idle_inputs();
    #4;
    check_both("rst.post", 0, 0, 0, 3'b000, 0, 0, 0, 3'b000);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
